// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate response checker.
// Holds the FSM state type, the pattern width, the bit positions of the three
// gates inside the {xor,or,and} vectors, and a 3-bit population count used to
// size the per-check error increment.
package gate_chk_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StDrive,
      StSettle,
      StCheck,
      StDone
   } state_e;

   localparam int unsigned PAT_W = 2;
   localparam int unsigned AND_B = 0;
   localparam int unsigned OR_B  = 1;
   localparam int unsigned XOR_B = 2;

   // Number of set bits in a 3-bit vector (0..3).
   function automatic logic [1:0] popcount3(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

endpackage

// File: rtl/gate_expect.sv
// Combinational golden model of the two-input gate unit.
// Ports:
//   pat_i  [1:0]  stimulus pattern {y,x}
//   exp_o  [2:0]  expected responses {xor,or,and}
module gate_expect
   import gate_chk_pkg::*;
(
   input  logic [PAT_W-1:0] pat_i,
   output logic [2:0]       exp_o
);

   logic x, y;

   assign x = pat_i[0];
   assign y = pat_i[1];

   always_comb begin
      exp_o        = '0;
      exp_o[AND_B] = x & y;
      exp_o[OR_B]  = x | y;
      exp_o[XOR_B] = x ^ y;
   end

endmodule

// File: rtl/gate_response_checker.sv
// Self-checking response end for the two-input AND/OR/XOR gate unit.
// Sweeps {y,x} through 00,01,10,11 (PASSES times), waits SETTLE_CYCLES after
// each drive, compares the registered gate responses against a golden table and
// accumulates sticky per-gate errors, a saturating error count and the first
// failing pattern.
// Ports:
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   start_i         begin a run; only sampled while idle
//   stim_x_o/y_o    stimulus to the gate unit
//   resp_*_i        gate unit AND/OR/XOR responses
//   busy_o          run in progress (including the done cycle)
//   done_o          one-cycle end-of-run pulse
//   pass_o          no mismatches in the last run; held until the next start
//   err_count_o     saturating count of mismatching (pattern, gate) checks
//   err_vec_o       sticky {xor,or,and} mismatch flags
//   fail_pattern_o  {y,x} of the first failing check
// All status outputs are registered, so they follow the FSM state by one cycle.
module gate_response_checker
   import gate_chk_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned PASSES        = 1,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   output logic             stim_x_o,
   output logic             stim_y_o,
   input  logic             resp_and_i,
   input  logic             resp_or_i,
   input  logic             resp_xor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [CNT_W-1:0] err_count_o,
   output logic [2:0]       err_vec_o,
   output logic [PAT_W-1:0] fail_pattern_o
);

   localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned SwpW = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [SwpW-1:0]  LastSweep = SwpW'(PASSES - 1);
   localparam logic [CNT_W+1:0] CntMax    = {2'b00, {CNT_W{1'b1}}};

   state_e           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [SwpW-1:0]  sweep_q, sweep_d;
   logic [SetW-1:0]  set_q, set_d;
   logic [PAT_W-1:0] stim_q, stim_d;
   logic [2:0]       resp_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       vec_q, vec_d;
   logic [PAT_W-1:0] fp_q, fp_d;
   logic             pass_q, pass_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic [2:0]       expect_v;
   logic [2:0]       mism;
   logic [CNT_W+1:0] sum;

   gate_expect u_expect (
      .pat_i (pat_q),
      .exp_o (expect_v)
   );

   assign mism = resp_q ^ expect_v;
   assign sum  = {2'b00, cnt_q} + (CNT_W+2)'(popcount3(mism));

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      sweep_d = sweep_q;
      set_d   = set_q;
      stim_d  = stim_q;
      cnt_d   = cnt_q;
      vec_d   = vec_q;
      fp_d    = fp_q;
      pass_d  = pass_q;
      done_d  = (state_q == StDone);
      busy_d  = (state_q != StIdle);

      unique case (state_q)
         StIdle: begin
            stim_d = '0;
            if (start_i) begin
               cnt_d   = '0;
               vec_d   = '0;
               fp_d    = '0;
               pass_d  = 1'b0;
               pat_d   = '0;
               sweep_d = '0;
               state_d = StDrive;
            end
         end
         StDrive: begin
            set_d   = SetW'(SETTLE_CYCLES);
            state_d = StSettle;
         end
         StSettle: begin
            set_d = set_q - SetW'(1);
            if (set_q == SetW'(1)) state_d = StCheck;
         end
         StCheck: begin
            cnt_d = (sum > CntMax) ? CntMax[CNT_W-1:0] : sum[CNT_W-1:0];
            vec_d = vec_q | mism;
            // The count only grows, so zero means no earlier mismatch this run.
            if ((mism != 3'b000) && (cnt_q == '0)) fp_d = pat_q;
            if ((pat_q == '1) && (sweep_q == LastSweep)) begin
               stim_d  = '0;
               state_d = StDone;
            end else begin
               pat_d   = pat_q + PAT_W'(1);
               if (pat_q == '1) sweep_d = sweep_q + SwpW'(1);
               // Stimulus only moves on DRIVE entry, keeping it stable for settle/check.
               stim_d  = pat_q + PAT_W'(1);
               state_d = StDrive;
            end
         end
         StDone: begin
            pass_d  = (cnt_q == '0);
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         pat_q   <= '0;
         sweep_q <= '0;
         set_q   <= '0;
         stim_q  <= '0;
         resp_q  <= '0;
         cnt_q   <= '0;
         vec_q   <= '0;
         fp_q    <= '0;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         sweep_q <= sweep_d;
         set_q   <= set_d;
         stim_q  <= stim_d;
         resp_q  <= {resp_xor_i, resp_or_i, resp_and_i};
         cnt_q   <= cnt_d;
         vec_q   <= vec_d;
         fp_q    <= fp_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign stim_x_o       = stim_q[0];
   assign stim_y_o       = stim_q[1];
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign pass_o         = pass_q;
   assign err_count_o    = cnt_q;
   assign err_vec_o      = vec_q;
   assign fail_pattern_o = fp_q;

endmodule
